// File: rtl/toggle_monitor.sv
// Counts rising/falling edges of a flip-flop output over a fixed window and
// holds the result for a valid/ready reader. Optional q/q_bar pair check: TOGGLE_MONITOR_PAIRCHK_EN.
module toggle_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             q,
    input  logic             q_bar,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic             busy,
    output logic             ovf,
    output logic             err
);

    localparam int WCNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [WCNT_W-1:0] WCNT_LOAD = WCNT_W'(WINDOW - 1);

    logic [1:0]        state;
    logic [WCNT_W-1:0] wcnt;
    logic              q_prev;
    logic              rise_evt;
    logic              fall_evt;
    logic              pair_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        if (en && (c != CNT_MAX))
            return c + CNT_W'(1);
        return c;
    endfunction

    // An increment request that finds the counter already at its ceiling.
    function automatic logic sat_hit(input logic [CNT_W-1:0] c, input logic en);
        return en && (c == CNT_MAX);
    endfunction

    assign rise_evt = q & ~q_prev;
    assign fall_evt = ~q & q_prev;
    assign busy     = (state != ST_IDLE);

`ifdef TOGGLE_MONITOR_PAIRCHK_EN
    assign pair_bad = (q == q_bar);
`else
    assign pair_bad = 1'b0;
    wire unused_q_bar = q_bar;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            wcnt     <= '0;
            q_prev   <= 1'b0;
            rise_cnt <= '0;
            fall_cnt <= '0;
            ovf      <= 1'b0;
            err      <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        q_prev   <= q;
                        rise_cnt <= '0;
                        fall_cnt <= '0;
                        ovf      <= 1'b0;
                        err      <= 1'b0;
                        wcnt     <= WCNT_LOAD;
                        state    <= ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    rise_cnt <= sat_inc(rise_cnt, rise_evt);
                    fall_cnt <= sat_inc(fall_cnt, fall_evt);
                    ovf      <= ovf | sat_hit(rise_cnt, rise_evt) | sat_hit(fall_cnt, fall_evt);
                    err      <= err | pair_bad;
                    q_prev   <= q;
                    // The wcnt==0 cycle still samples an edge; it is the last one of the window.
                    if (wcnt == '0) begin
                        state    <= ST_HOLD;
                        rd_valid <= 1'b1;
                    end else begin
                        wcnt <= wcnt - WCNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (rd_ready) begin
                        state    <= ST_IDLE;
                        rd_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_toggle_monitor.sv
// Bench for toggle_monitor: two instances (8-bit/16-cycle and 3-bit/32-cycle)
// checked against a transition-counting model of the sampled q sequence.
module tb_toggle_monitor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic q = 1'b0;
    logic q_bar = 1'b1;
    logic start8 = 1'b0, rd_ready8 = 1'b0;
    logic start3 = 1'b0, rd_ready3 = 1'b0;

    logic       rd_valid8, busy8, ovf8, err8;
    logic [7:0] rise8, fall8;
    logic       rd_valid3, busy3, ovf3, err3;
    logic [2:0] rise3, fall3;

    int total = 0;
    int bad = 0;

`ifdef TOGGLE_MONITOR_PAIRCHK_EN
    localparam bit PAIRCHK = 1'b1;
`else
    localparam bit PAIRCHK = 1'b0;
`endif

    always #5 clk = ~clk;

    toggle_monitor #(.CNT_W(8), .WINDOW(16)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .q(q), .q_bar(q_bar),
        .rd_ready(rd_ready8), .rd_valid(rd_valid8), .rise_cnt(rise8),
        .fall_cnt(fall8), .busy(busy8), .ovf(ovf8), .err(err8)
    );

    toggle_monitor #(.CNT_W(3), .WINDOW(32)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .q(q), .q_bar(q_bar),
        .rd_ready(rd_ready3), .rd_valid(rd_valid3), .rise_cnt(rise3),
        .fall_cnt(fall3), .busy(busy3), .ovf(ovf3), .err(err3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap(input bit sel, output logic [31:0] v, output logic [31:0] r,
                        output logic [31:0] f, output logic [31:0] b,
                        output logic [31:0] o, output logic [31:0] e);
        if (sel) begin
            v = {31'd0, rd_valid3}; r = {29'd0, rise3}; f = {29'd0, fall3};
            b = {31'd0, busy3};     o = {31'd0, ovf3};  e = {31'd0, err3};
        end else begin
            v = {31'd0, rd_valid8}; r = {24'd0, rise8}; f = {24'd0, fall8};
            b = {31'd0, busy8};     o = {31'd0, ovf8};  e = {31'd0, err8};
        end
    endtask

    task automatic check_all_zero(input bit sel, input string tag);
        logic [31:0] v, r, f, b, o, e;
        snap(sel, v, r, f, b, o, e);
        check({tag, ".rd_valid"}, v, 0);
        check({tag, ".rise"}, r, 0);
        check({tag, ".fall"}, f, 0);
        check({tag, ".busy"}, b, 0);
        check({tag, ".ovf"}, o, 0);
        check({tag, ".err"}, e, 0);
    endtask

    // pattern: 0 toggle from 0, 1 constant one, 2 random.
    // q_bar equals q for edges inj..inj+2 of the window.
    task automatic run_window(input bit sel, input int pattern, input int inj, input int hold,
                              input bit start_in_hs, input string tag);
        int win = sel ? 32 : 16;
        int maxc = sel ? 7 : 255;
        bit smp[$];
        int rises = 0, falls = 0;
        bit perr = 1'b0;
        logic [31:0] v, r, f, b, o, e;
        logic [31:0] er, ef, eo, ee;

        @(negedge clk);
        for (int k = 0; k <= win; k++) begin
            case (pattern)
                0:       q = 1'(k & 1);
                1:       q = 1'b1;
                default: q = 1'($urandom_range(0, 1));
            endcase
            q_bar = (k >= inj && k < inj + 3) ? q : ~q;
            smp.push_back(q);
            if (k > 0 && q == q_bar) perr = 1'b1;
            if (k == 0) begin
                if (sel) start3 = 1'b1; else start8 = 1'b1;
            end
            @(negedge clk);
            start8 = 1'b0;
            start3 = 1'b0;
            snap(sel, v, r, f, b, o, e);
            check({tag, ".busy_count"}, b, 1);
            if (k < win) check({tag, ".rd_valid_early"}, v, 0);
        end

        for (int i = 1; i < smp.size(); i++) begin
            if (!smp[i-1] && smp[i]) rises++;
            if (smp[i-1] && !smp[i]) falls++;
        end
        er = (rises > maxc) ? maxc : rises;
        ef = (falls > maxc) ? maxc : falls;
        eo = ((rises > maxc) || (falls > maxc)) ? 1 : 0;
        ee = (PAIRCHK && perr) ? 1 : 0;

        q_bar = ~q;
        check({tag, ".rd_valid"}, v, 1);
        check({tag, ".rise"}, r, er);
        check({tag, ".fall"}, f, ef);
        check({tag, ".ovf"}, o, eo);
        check({tag, ".err"}, e, ee);

        for (int h = 0; h < hold; h++) begin
            q = 1'($urandom_range(0, 1));
            q_bar = q;
            @(negedge clk);
            snap(sel, v, r, f, b, o, e);
            check({tag, ".hold_valid"}, v, 1);
            check({tag, ".hold_rise"}, r, er);
            check({tag, ".hold_fall"}, f, ef);
            check({tag, ".hold_ovf"}, o, eo);
            check({tag, ".hold_err"}, e, ee);
        end
        q_bar = ~q;

        if (sel) begin rd_ready3 = 1'b1; start3 = start_in_hs; end
        else     begin rd_ready8 = 1'b1; start8 = start_in_hs; end
        @(negedge clk);
        rd_ready8 = 1'b0; rd_ready3 = 1'b0; start8 = 1'b0; start3 = 1'b0;
        snap(sel, v, r, f, b, o, e);
        check({tag, ".done_valid"}, v, 0);
        check({tag, ".done_busy"}, b, 0);
        check({tag, ".kept_rise"}, r, er);
        check({tag, ".kept_fall"}, f, ef);
        @(negedge clk);
        snap(sel, v, r, f, b, o, e);
        check({tag, ".idle_busy"}, b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_all_zero(0, "rst8");
        check_all_zero(1, "rst3");
        #8;
        reset = 1'b0;
        #1;
        check_all_zero(0, "rel8");
        check_all_zero(1, "rel3");

        run_window(0, 0, 1000, 0, 1'b1, "toggle16");
        run_window(0, 1, 1000, 5, 1'b0, "ones16");
        run_window(1, 0, 1000, 2, 1'b1, "toggle32");
        run_window(0, 0, 6, 1, 1'b0, "pair16");
        run_window(1, 2, 10, 1, 1'b0, "pair32");
        for (int i = 0; i < 4; i++) begin
            run_window(0, 2, 1000, $urandom_range(0, 3), 1'b0, "rand16");
            run_window(1, 2, 1000, $urandom_range(0, 3), 1'b0, "rand32");
        end

        // Asynchronous reset in the middle of a window.
        @(negedge clk);
        q = 1'b0; q_bar = 1'b1; start8 = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            q = 1'(k & 1);
            q_bar = (k == 3) ? q : ~q;
        end
        #2 reset = 1'b1;
        #1 check_all_zero(0, "midrst");
        @(negedge clk);
        reset = 1'b0;
        q_bar = ~q;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("postrst.busy", {31'd0, busy8}, 0);
        end
        run_window(0, 2, 1000, 1, 1'b0, "fresh16");
        run_window(0, 0, 1000, 0, 1'b0, "fresh_toggle16");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
